// File: rtl/pic_pkg.sv
// Shared constants and types for the multi-channel programmable interrupt controller.
package pic_pkg;

  // Register select values on addr
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_IMR  = 2'd1;
  localparam logic [1:0] ADDR_CMD  = 2'd2;  // write side of address 2
  localparam logic [1:0] ADDR_IRR  = 2'd2;  // read side of address 2
  localparam logic [1:0] ADDR_ISR  = 2'd3;  // read only

  // Command encodings carried in wdata[2:0] of a CMD write
  localparam logic [2:0] CMD_NS_EOI  = 3'b001;  // clear highest-priority ISR bit
  localparam logic [2:0] CMD_SP_EOI  = 3'b011;  // clear ISR bit named in wdata[12:8]
  localparam logic [2:0] CMD_ROT_EOI = 3'b101;  // non-specific EOI, LP = cleared id
  localparam logic [2:0] CMD_SET_LP  = 3'b111;  // LP = wdata[12:8]

  // CTRL bit positions
  localparam int CTRL_LTIM     = 0;
  localparam int CTRL_AEOI     = 1;
  localparam int CTRL_AROT     = 2;
  localparam int CTRL_BASE_LSB = 8;

  // Only the defined CTRL fields are stored
  localparam logic [15:0] CTRL_WMASK = 16'hFF07;

  // Acknowledge sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK1 = 2'd1,
    ST_WAIT_ACK2 = 2'd2
  } pic_state_t;

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority resolver: picks the first set request after the
// lowest-priority pointer lp, scanning lp+1, lp+2, ... modulo NUM_IRQ.
module pic_prio_resolver #(
  parameter int NUM_IRQ = 16,
  localparam int IDW = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [IDW-1:0]     lp,
  output logic               valid,
  output logic [IDW-1:0]     id
);

  // rot[k] is the request that sits k+1 places after lp; NUM_IRQ is a power
  // of two so IDW-bit arithmetic wraps for free.
  logic [IDW-1:0]     idx [NUM_IRQ];
  logic [NUM_IRQ-1:0] rot;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
    assign idx[gi] = lp + IDW'(gi + 1);
    assign rot[gi] = req[idx[gi]];
  end

  // Lowest rotated index wins; scan from the top so the last hit is the winner
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        id    = idx[k];
      end
    end
  end

endmodule

// File: rtl/multi_channel_pic.sv
// Multi-channel PIC: edge/level request capture, mask, rotating priority,
// fully nested in-service tracking, two-pulse acknowledge and EOI commands.
module multi_channel_pic
  import pic_pkg::*;
#(
  parameter int NUM_IRQ  = 16,
  parameter int VECTOR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                wr_enable,
  input  logic                rd_enable,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                intr,
  input  logic                inta_n,
  output logic [VECTOR_W-1:0] vector,
  output logic                vec_valid
);

  localparam int IDW = $clog2(NUM_IRQ);
  localparam logic [IDW-1:0] SPURIOUS_ID = IDW'(NUM_IRQ - 1);

  logic [15:0]         ctrl;
  logic [NUM_IRQ-1:0]  imr;
  logic [NUM_IRQ-1:0]  irr;
  logic [NUM_IRQ-1:0]  isr;
  logic [NUM_IRQ-1:0]  irq_prev;
  logic [IDW-1:0]      lp;
  logic [IDW-1:0]      ack_id;
  logic                ack_spurious;
  pic_state_t          state;

  logic [NUM_IRQ-1:0]  irr_next;
  logic [NUM_IRQ-1:0]  isr_next;
  logic [NUM_IRQ-1:0]  isr_set;
  logic [NUM_IRQ-1:0]  isr_clr;
  logic [NUM_IRQ-1:0]  irr_clr;
  logic [IDW-1:0]      lp_next;

  logic                win_valid;
  logic [IDW-1:0]      win_id;
  logic                isr_valid;
  logic [IDW-1:0]      isr_id;
  logic [IDW-1:0]      win_rank;
  logic [IDW-1:0]      isr_rank;
  logic                int_cond;

  logic                ack1;
  logic                ack2;
  logic                cmd_wr;
  logic [2:0]          cmd;
  logic [IDW-1:0]      cmd_id;
  logic                cmd_id_ok;
  logic [VECTOR_W-1:0] base_ext;
  logic                unused_wdata;

  assign ack1      = (state == ST_WAIT_ACK1) && !inta_n;
  assign ack2      = (state == ST_WAIT_ACK2) && !inta_n;
  assign cmd_wr    = wr_enable && (addr == ADDR_CMD);
  assign cmd       = wdata[2:0];
  assign cmd_id    = wdata[8 +: IDW];
  assign cmd_id_ok = ({27'd0, wdata[12:8]} < 32'(NUM_IRQ));
  assign base_ext  = VECTOR_W'(ctrl[15:CTRL_BASE_LSB]);
  assign unused_wdata = ^wdata[31:16];

  // Winner among unmasked pending requests, and highest in-service level
  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_win_res (
    .req   (irr & ~imr),
    .lp    (lp),
    .valid (win_valid),
    .id    (win_id)
  );

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
    .req   (isr),
    .lp    (lp),
    .valid (isr_valid),
    .id    (isr_id)
  );

  // Rank 0 is the highest priority under the current rotation
  assign win_rank = win_id - lp - IDW'(1);
  assign isr_rank = isr_id - lp - IDW'(1);
  assign int_cond = win_valid && (!isr_valid || (win_rank < isr_rank));

  // Next-state for IRR, ISR and LP from acknowledge, auto-EOI and commands
  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    irr_clr = '0;
    lp_next = lp;
    if (ack1 && win_valid) begin
      isr_set[win_id] = 1'b1;
      irr_clr[win_id] = 1'b1;
    end
    if (ack2 && ctrl[CTRL_AEOI] && !ack_spurious) begin
      isr_clr[ack_id] = 1'b1;
      if (ctrl[CTRL_AROT]) lp_next = ack_id;
    end
    if (cmd_wr) begin
      case (cmd)
        CMD_NS_EOI:  if (isr_valid) isr_clr[isr_id] = 1'b1;
        CMD_ROT_EOI: if (isr_valid) begin
                       isr_clr[isr_id] = 1'b1;
                       lp_next         = isr_id;
                     end
        CMD_SP_EOI:  if (cmd_id_ok) isr_clr[cmd_id] = 1'b1;
        CMD_SET_LP:  if (cmd_id_ok) lp_next = cmd_id;
        default:     ;
      endcase
    end
    isr_next = (isr & ~isr_clr) | isr_set;
    irr_next = ctrl[CTRL_LTIM] ? irq : ((irr & ~irr_clr) | (irq & ~irq_prev));
  end

  // Programmable registers, request/service state and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      imr      <= '1;
      irr      <= '0;
      isr      <= '0;
      irq_prev <= '0;
      lp       <= SPURIOUS_ID;
      rdata    <= '0;
    end else begin
      irq_prev <= irq;
      irr      <= irr_next;
      isr      <= isr_next;
      lp       <= lp_next;
      if (wr_enable && addr == ADDR_CTRL) ctrl <= wdata[15:0] & CTRL_WMASK;
      if (wr_enable && addr == ADDR_IMR)  imr  <= wdata[NUM_IRQ-1:0];
      if (rd_enable) begin
        case (addr)
          ADDR_CTRL: rdata <= 32'(ctrl);
          ADDR_IMR:  rdata <= 32'(imr);
          ADDR_IRR:  rdata <= 32'(irr);
          default:   rdata <= 32'(isr);
        endcase
      end
    end
  end

  // Acknowledge sequencer with registered INT, frozen id and vector output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      intr         <= 1'b0;
      ack_id       <= '0;
      ack_spurious <= 1'b0;
      vector       <= '0;
      vec_valid    <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          intr <= int_cond;
          if (int_cond) state <= ST_WAIT_ACK1;
        end
        ST_WAIT_ACK1: begin
          if (!inta_n) begin
            state        <= ST_WAIT_ACK2;
            intr         <= 1'b0;
            ack_id       <= win_valid ? win_id : SPURIOUS_ID;
            ack_spurious <= !win_valid;
          end else begin
            intr <= int_cond;
          end
        end
        ST_WAIT_ACK2: begin
          intr <= 1'b0;
          if (!inta_n) begin
            state     <= ST_IDLE;
            vector    <= {base_ext[VECTOR_W-1:IDW], ack_id};
            vec_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multi_channel_pic.md
MULTI_CHANNEL_PIC -- requirements
Module: multi_channel_pic

Interface
REQ-001 Parameter NUM_IRQ, default 16, SHALL set the request-line count; legal values are powers of two from 2 to 32; IDW = clog2(NUM_IRQ).
REQ-002 Parameter VECTOR_W, default 8, SHALL set the vector width; VECTOR_W > IDW.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_  in  1  asynchronous, active-low reset.
REQ-005 IRQ  in  NUM_IRQ  request lines, synchronous to CLK, bit 0 = IRQ0.
REQ-006 WR_ENABLE  in  1  one-cycle write strobe.
REQ-007 RD_ENABLE  in  1  one-cycle read strobe.
REQ-008 ADDR  in  2  register select: 0 CTRL, 1 IMR, 2 CMD (write) / IRR (read), 3 ISR (read only).
REQ-009 WDATA  in  32  write data; RDATA  out  32  read data, zero-extended.
REQ-010 INT  out  1  interrupt request to processor.
REQ-011 INTA_  in  1  active-low acknowledge, one-cycle low pulse per acknowledge.
REQ-012 VECTOR  out  VECTOR_W  vector; VEC_VALID  out  1  one-cycle qualifier.

Function
REQ-013 CTRL fields: [0] LTIM (1 level, 0 edge), [1] AEOI, [2] AUTO_ROTATE, [15:8] base; VECTOR = {base[VECTOR_W-1:IDW], id}.
REQ-014 Edge mode: IRR bit set on a sampled 0->1 of IRQ, held until acknowledged; level mode: IRR bit follows IRQ each cycle.
REQ-015 Masked IRR bits SHALL still be recorded but SHALL NOT compete in priority resolution.
REQ-016 Priority SHALL be rotating: pointer LP (lowest priority id); order is LP+1, LP+2, ... mod NUM_IRQ; reset LP = NUM_IRQ-1 (IRQ0 highest).
REQ-017 Fully nested: INT SHALL be 1 while the winning unmasked IRR bit outranks every set ISR bit (or ISR is zero), registered, 1-cycle latency from IRR change.
REQ-018 FSM states IDLE, WAIT_ACK1, WAIT_ACK2: IDLE->WAIT_ACK1 when INT rises; WAIT_ACK1->WAIT_ACK2 on INTA_ low; WAIT_ACK2->IDLE on INTA_ low.
REQ-019 On first INTA_ low: winner id frozen, ISR[id] set, IRR[id] cleared (edge mode), INT deasserted.
REQ-020 If no valid winner exists at first INTA_ (request withdrawn or masked), id = NUM_IRQ-1 is returned as spurious with ISR unchanged.
REQ-021 On second INTA_ low: VECTOR driven and VEC_VALID = 1 the following cycle; if AEOI, ISR[id] cleared in that cycle, with LP = id when AUTO_ROTATE.
REQ-022 CMD writes, WDATA[2:0]: 001 non-specific EOI (clear highest-priority ISR bit), 011 specific EOI (id = WDATA[12:8]), 101 non-specific EOI with LP = cleared id, 111 set LP = WDATA[12:8], others no-op.
REQ-023 Non-specific EOI with ISR zero SHALL be a no-op; ids >= NUM_IRQ SHALL be ignored.
REQ-024 Same-cycle ISR set and EOI clear: ISR_next = (ISR & ~clr) | set.
REQ-025 Reads: RDATA registered, valid the cycle after RD_ENABLE; CTRL, IMR, IRR, ISR by ADDR.
REQ-026 CTRL/IMR writes during WAIT states SHALL take effect immediately; the acknowledge sequence continues.
REQ-027 INTA_ low in IDLE SHALL be ignored.

Reset
REQ-028 RST_ low: CTRL = 0, IMR = all ones, IRR = ISR = 0, LP = NUM_IRQ-1, FSM = IDLE, INT = 0, VECTOR = 0, VEC_VALID = 0, RDATA = 0, edge-history = 0; a mid-sequence reset aborts the acknowledge.

Structure
REQ-029 Shared package pic_pkg SHALL hold register address constants, CMD encodings, CTRL bit positions and the FSM state typedef.
REQ-030 Combinational rotating priority resolver SHALL be sub-module pic_prio_resolver (inputs request vector, LP; outputs valid, id).

Verification (NUM_IRQ = 16, VECTOR_W = 8)
REQ-031 Base 0x40, IMR 0, edge IRQ3 pulse, two INTA_ -> INT rises, VECTOR 0x43, ISR 0x0008.
REQ-032 IRQ5 in service, IRQ2 rises -> INT reasserts; IRQ9 rises -> no INT until EOI CMD 001 clears ISR5.
REQ-033 AEOI + AUTO_ROTATE, IRQ0 and IRQ1 pending -> vectors 0x40 then 0x41, LP = 1 after the second; ISR 0 after each.
REQ-034 IMR set to 0xFFFF between INT rise and first INTA_ -> VECTOR 0x4F, ISR unchanged.
REQ-035 CMD 111 with id 7, IRQ3 and IRQ8 pending -> IRQ8 served first.
REQ-036 RST_ low during WAIT_ACK2 -> INT 0, ISR 0, IMR 0xFFFF, no VEC_VALID.
